// File: rtl/input_debounce_pkg.sv
// Shared constants for the input debouncer: default sample divider, stable count
// and the fixed stable-counter width.
package input_debounce_pkg;

   localparam int unsigned DEF_DIV    = 1000;
   localparam int unsigned DEF_STABLE = 4;
   localparam int unsigned CNT_W      = 4;

endpackage : input_debounce_pkg

// File: rtl/debounce_bit.sv
// One debounced input: two-flop synchronizer, stable counter advanced on the shared
// sample tick, debounced level and registered rise/fall pulses.
module debounce_bit
   import input_debounce_pkg::*;
#(
   parameter int unsigned STABLE = DEF_STABLE
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_accept;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   // A change is accepted on the tick where the counter would reach STABLE.
   assign w_accept  = i_tick && (r_sync2 != r_level) && (w_cnt_inc == STABLE_C);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise <= w_accept && !r_level;
         r_fall <= w_accept && r_level;
         if (i_tick) begin
            if (r_sync2 == r_level) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_cnt   <= '0;
               r_level <= ~r_level;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule : debounce_bit

// File: rtl/input_debounce.sv
// Debouncer for NBTN push-buttons and NSW slide-switches sharing one sample prescaler.
// Define INPUT_DEBOUNCE_CNT_EN to build the 8-bit wrapping press counter; otherwise press_cnt is 0.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int unsigned NBTN   = 4,
   parameter int unsigned NSW    = 8,
   parameter int unsigned DIV    = DEF_DIV,
   parameter int unsigned STABLE = DEF_STABLE
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NBTN-1:0] btn_in,
   input  logic [NSW-1:0]  sw_in,
   output logic [NBTN-1:0] btn,
   output logic [NSW-1:0]  sw,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic            sw_change,
   output logic [7:0]      press_cnt
);

   localparam int unsigned PW = $clog2(DIV);

   logic [PW-1:0]  r_pre;
   logic           w_tick;
   logic [NSW-1:0] w_sw_rise;
   logic [NSW-1:0] w_sw_fall;

   assign w_tick = (r_pre == PW'(DIV - 1));

   // Sample prescaler: 0..DIV-1, tick on the terminal count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   for (genvar i = 0; i < NBTN; i++) begin : g_btn
      debounce_bit #(.STABLE(STABLE)) u_bit (
         .clk     (clk),
         .reset   (reset),
         .i_raw   (btn_in[i]),
         .i_tick  (w_tick),
         .o_level (btn[i]),
         .o_rise  (btn_press[i]),
         .o_fall  (btn_release[i])
      );
   end

   for (genvar i = 0; i < NSW; i++) begin : g_sw
      debounce_bit #(.STABLE(STABLE)) u_bit (
         .clk     (clk),
         .reset   (reset),
         .i_raw   (sw_in[i]),
         .i_tick  (w_tick),
         .o_level (sw[i]),
         .o_rise  (w_sw_rise[i]),
         .o_fall  (w_sw_fall[i])
      );
   end

   assign sw_change = |(w_sw_rise | w_sw_fall);

`ifdef INPUT_DEBOUNCE_CNT_EN
   logic [7:0] r_press_cnt;
   logic [7:0] w_press_inc;

   always_comb begin
      w_press_inc = '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
         w_press_inc = w_press_inc + 8'(btn_press[i]);
      end
   end

   // Wraps modulo 256 by design.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_press_cnt <= '0;
      end else begin
         r_press_cnt <= r_press_cnt + w_press_inc;
      end
   end

   assign press_cnt = r_press_cnt;
`else
   assign press_cnt = 8'd0;
`endif

endmodule : input_debounce
